// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM encoding, opcode values,
// instruction field positions and the program_counter control bundle.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_UPDATE = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   // Opcode values found in instr[OPC_MSB:OPC_LSB]; anything else is a NOP.
   localparam logic [3:0] OP_BRF  = 4'h1;
   localparam logic [3:0] OP_BRB  = 4'h2;
   localparam logic [3:0] OP_BZF  = 4'h3;
   localparam logic [3:0] OP_BZB  = 4'h4;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Instruction field positions.
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_MSB = 11;
   localparam int IMM_LSB = 0;
   localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
   localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

   // One-hot program_counter command; all-zero means "no update".
   typedef struct packed {
      logic inc;
      logic add;
      logic sub;
   } pc_ctrl_t;

   localparam pc_ctrl_t CTRL_NONE = 3'b000;
   localparam pc_ctrl_t CTRL_INC  = 3'b100;
   localparam pc_ctrl_t CTRL_ADD  = 3'b010;
   localparam pc_ctrl_t CTRL_SUB  = 3'b001;

   // Retired-instruction counter step that sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port. The sequencer is the master: it raises
// imem_req with imem_addr and waits for imem_ack with imem_rdata.
interface pc_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/branch_decode.sv
// Combinational decode of one instruction into a program_counter command:
// which of inc/add/sub to pulse, the offset operand, and whether it is HALT.
module branch_decode
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [OPC_W-1:0]  opcode,
   input  logic [IMM_W-1:0]  imm,
   input  logic              flag_z,
   output pc_ctrl_t          sel,
   output logic [ADDR_W-1:0] offset,
   output logic              is_halt
);

   logic [ADDR_W-1:0] imm_ext;

   assign imm_ext = ADDR_W'(imm);

   // Map opcode and zero flag onto a single pc command; offset stays 0 for inc.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      sel     = CTRL_INC;
      offset  = '0;
      is_halt = 1'b0;
      case (opcode)
         OP_BRF: begin
            sel    = CTRL_ADD;
            offset = imm_ext;
         end
         OP_BRB: begin
            sel    = CTRL_SUB;
            offset = imm_ext;
         end
         OP_BZF: begin
            if (flag_z) begin
               sel    = CTRL_ADD;
               offset = imm_ext;
            end
         end
         OP_BZB: begin
            if (flag_z) begin
               sel    = CTRL_SUB;
               offset = imm_ext;
            end
         end
         OP_HALT: begin
            sel     = CTRL_NONE;
            is_halt = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches a word at the external pc, decodes it and
// issues one inc/add/sub pulse to the external program_counter per
// instruction (FETCH -> DECODE -> UPDATE), stopping for good on HALT.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     pc,
   input  logic                  flag_z,
   pc_sequencer_if.master        imem,
   output logic                  inc,
   output logic                  add,
   output logic                  sub,
   output logic [ADDR_W-1:0]     offset,
   output logic                  halted,
   output logic [15:0]           instr_count
);

   state_t            state;
   logic [DATA_W-1:0] instr;
   logic              req_q;
   pc_ctrl_t          ctrl_q;

   pc_ctrl_t          dec_sel;
   logic [ADDR_W-1:0] dec_offset;
   logic              dec_halt;

   branch_decode #(
      .ADDR_W (ADDR_W)
   ) u_branch_decode (
      .opcode  (instr[OPC_MSB:OPC_LSB]),
      .imm     (instr[IMM_MSB:IMM_LSB]),
      .flag_z  (flag_z),
      .sel     (dec_sel),
      .offset  (dec_offset),
      .is_halt (dec_halt)
   );

   // The address follows pc combinationally: pc only settles on the edge
   // that enters FETCH, so a registered copy would present the old value.
   assign imem.imem_req  = req_q;
   assign imem.imem_addr = req_q ? pc : '0;

   assign inc = ctrl_q.inc;
   assign add = ctrl_q.add;
   assign sub = ctrl_q.sub;

   // Sequencer FSM with registered request, control pulses, halt and count.
   always_ff @(posedge clk) begin
      // NOTE: all state here is assigned with <= so every register samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         state       <= ST_IDLE;
         instr       <= '0;
         req_q       <= 1'b0;
         ctrl_q      <= CTRL_NONE;
         offset      <= '0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
                  req_q <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem.imem_ack) begin
                  instr <= imem.imem_rdata;
                  req_q <= 1'b0;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_halt) begin
                  state       <= ST_HALTED;
                  halted      <= 1'b1;
                  instr_count <= sat_inc16(instr_count);
               end else begin
                  state  <= ST_UPDATE;
                  ctrl_q <= dec_sel;
                  offset <= dec_offset;
               end
            end
            ST_UPDATE: begin
               ctrl_q      <= CTRL_NONE;
               offset      <= '0;
               instr_count <= sat_inc16(instr_count);
               req_q       <= 1'b1;
               state       <= ST_FETCH;
            end
            ST_HALTED: ;
            default: begin
               state  <= ST_IDLE;
               req_q  <= 1'b0;
               ctrl_q <= CTRL_NONE;
               offset <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the external program_counter, drives
// directed instruction words, and compares every cycle against expectations
// derived from the instruction semantics, plus literal spot values.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flag_z;
   logic [15:0] pc_q;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic        inc, add, sub;
   logic [15:0] offset;
   logic        halted;
   logic [15:0] instr_count;

   pc_sequencer_if #(.ADDR_W(16), .DATA_W(16)) imem ();

   pc_sequencer #(
      .ADDR_W (16),
      .DATA_W (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pc          (pc_q),
      .flag_z      (flag_z),
      .imem        (imem),
      .inc         (inc),
      .add         (add),
      .sub         (sub),
      .offset      (offset),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // External program_counter reacting to the sequencer's pulses.
   always @(posedge clk) begin
      if (pc_load)  pc_q <= pc_load_val;
      else if (inc) pc_q <= pc_q + 16'd1;
      else if (add) pc_q <= pc_q + offset;
      else if (sub) pc_q <= pc_q - offset;
   end

   int n_vec = 0;
   int n_err = 0;

   // Expected outputs for the current cycle.
   logic        chk_en = 1'b0;
   logic        exp_req, exp_inc, exp_add, exp_sub, exp_halted;
   logic [15:0] exp_pc, exp_off, exp_count;

   logic [2:0]  seen_ctrl;
   logic [15:0] seen_off;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the expectation registers.
   always @(negedge clk) begin
      if (chk_en) begin
         check("imem_req", imem.imem_req, exp_req);
         if (exp_req) check("imem_addr", imem.imem_addr, exp_pc);
         check("inc", inc, exp_inc);
         check("add", add, exp_add);
         check("sub", sub, exp_sub);
         check("offset", offset, exp_off);
         check("halted", halted, exp_halted);
         check("instr_count", instr_count, exp_count);
      end
   end

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_quiet();
      exp_req = 1'b0;
      exp_inc = 1'b0;
      exp_add = 1'b0;
      exp_sub = 1'b0;
      exp_off = 16'h0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      expect_quiet();
      exp_count  = 16'h0000;
      exp_halted = 1'b0;
   endtask

   task automatic load_pc(input logic [15:0] v);
      pc_load     = 1'b1;
      pc_load_val = v;
      step();
      pc_load = 1'b0;
      exp_pc  = v;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      expect_quiet();
      exp_req = 1'b1;
   endtask

   // Runs one instruction from the first FETCH cycle. kind: 0 inc, 1 add,
   // 2 sub, 3 halt. Optionally resets during the UPDATE cycle.
   task automatic exec_instr(input logic [15:0] word, input logic fz, input int waits,
                             input bit rst_at_update);
      int          kind;
      logic [15:0] imm;
      for (int w = 0; w < waits; w++) begin
         imem.imem_ack   = 1'b0;
         imem.imem_rdata = 16'hDEAD;
         step();
      end
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = word;
      step();
      // DECODE: ack stays high with junk data; it must be ignored now.
      imem.imem_rdata = 16'hBEEF;
      expect_quiet();
      flag_z = fz;
      step();
      imem.imem_ack = 1'b0;
      flag_z        = ~fz;
      seen_ctrl     = {inc, add, sub};
      seen_off      = offset;
      imm           = {4'h0, word[11:0]};
      case (word[15:12])
         4'h1:    kind = 1;
         4'h2:    kind = 2;
         4'h3:    kind = fz ? 1 : 0;
         4'h4:    kind = fz ? 2 : 0;
         4'hF:    kind = 3;
         default: kind = 0;
      endcase
      if (kind == 3) begin
         exp_halted = 1'b1;
         exp_count  = sat16(exp_count);
      end else begin
         exp_inc = (kind == 0);
         exp_add = (kind == 1);
         exp_sub = (kind == 2);
         exp_off = (kind == 0) ? 16'h0000 : imm;
         if (rst_at_update) begin
            do_reset();
         end else begin
            step();
            case (kind)
               0:       exp_pc = exp_pc + 16'd1;
               1:       exp_pc = exp_pc + imm;
               default: exp_pc = exp_pc - imm;
            endcase
            exp_count = sat16(exp_count);
            expect_quiet();
            exp_req = 1'b1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      flag_z          = 1'b0;
      pc_load         = 1'b0;
      pc_load_val     = 16'h0000;
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 16'h0000;
      exp_pc          = 16'h0000;
      step();
      do_reset();
      chk_en = 1'b1;
      check("reset_count", instr_count, 16'h0000);
      check("reset_req", imem.imem_req, 1'b0);

      // Ack while idle must not start anything.
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 16'hF000;
      load_pc(16'h0000);
      imem.imem_ack   = 1'b0;
      step();

      // NOP from address 0.
      do_start();
      check("nop_addr", imem.imem_addr, 16'h0000);
      exec_instr(16'h0000, 1'b0, 0, 1'b0);
      check("nop_pulse", seen_ctrl, 3'b100);
      check("nop_next_addr", imem.imem_addr, 16'h0001);
      check("nop_count", instr_count, 16'h0001);

      // Forward branches: 0x0001 -> 0x0010 -> 0x00B5.
      exec_instr(16'h100F, 1'b0, 0, 1'b0);
      check("brf_to_10", imem.imem_addr, 16'h0010);
      exec_instr(16'h10A5, 1'b0, 0, 1'b0);
      check("brf_pulse", seen_ctrl, 3'b010);
      check("brf_offset", seen_off, 16'h00A5);
      check("brf_next_addr", imem.imem_addr, 16'h00B5);

      // Conditional backward branch, taken then not taken.
      exec_instr(16'h4014, 1'b1, 0, 1'b0);
      check("bzb_t_pulse", seen_ctrl, 3'b001);
      check("bzb_t_offset", seen_off, 16'h0014);
      check("bzb_t_addr", imem.imem_addr, 16'h00A1);
      exec_instr(16'h4014, 1'b0, 0, 1'b0);
      check("bzb_n_pulse", seen_ctrl, 3'b100);
      check("bzb_n_offset", seen_off, 16'h0000);
      check("bzb_n_addr", imem.imem_addr, 16'h00A2);

      // BZF taken, zero-offset BRB, unknown opcode, BZF not taken.
      exec_instr(16'h3003, 1'b1, 0, 1'b0);
      exec_instr(16'h2000, 1'b0, 0, 1'b0);
      check("brb0_pulse", seen_ctrl, 3'b001);
      check("brb0_addr", imem.imem_addr, 16'h00A5);
      exec_instr(16'h7123, 1'b1, 0, 1'b0);
      exec_instr(16'h3010, 1'b0, 0, 1'b0);
      check("bzf_n_addr", imem.imem_addr, 16'h00A7);

      // Four wait states before the ack.
      exec_instr(16'h0000, 1'b0, 4, 1'b0);
      check("wait_addr", imem.imem_addr, 16'h00A8);
      check("wait_count", instr_count, 16'd10);

      // Reset landing on the UPDATE cycle.
      exec_instr(16'h1001, 1'b0, 0, 1'b1);
      check("upd_rst_count", instr_count, 16'h0000);
      check("upd_rst_add", add, 1'b0);
      step();
      step();

      // HALT: counted, no pulse, start ignored afterwards.
      load_pc(16'h0200);
      do_start();
      exec_instr(16'hF000, 1'b0, 0, 1'b0);
      check("halt_pulse", seen_ctrl, 3'b000);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         step();
         start = 1'b0;
         step();
      end
      check("halt_stays", halted, 1'b1);
      check("halt_count", instr_count, 16'h0001);

      // Reset while a fetch is pending.
      do_reset();
      load_pc(16'h0000);
      do_start();
      exec_instr(16'h0000, 1'b0, 0, 1'b0);
      imem.imem_ack = 1'b0;
      step();
      do_reset();
      check("mid_rst_req", imem.imem_req, 1'b0);
      check("mid_rst_count", instr_count, 16'h0000);
      for (int i = 0; i < 3; i++) step();
      do_start();
      check("resume_addr", imem.imem_addr, 16'h0001);
      exec_instr(16'h0000, 1'b0, 0, 1'b0);
      check("resume_count", instr_count, 16'h0001);
      step();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
